// File: rtl/md_unit.sv
// Multiply/divide unit with architectural HI/LO registers.
// Results are computed when an operation is accepted and become visible after a fixed busy window.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall_req
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_temp_hi;
    logic [31:0]        r_temp_lo;

    logic               w_is_md;
    logic               w_is_mult;
    logic               w_is_valid;
    logic signed [63:0] w_a_s;
    logic signed [63:0] w_b_s;
    logic signed [63:0] w_mul_s;
    logic [63:0]        w_mul_u;
    logic [31:0]        w_div_q;
    logic [31:0]        w_div_r;
    logic [31:0]        w_divu_q;
    logic [31:0]        w_divu_r;
    logic [31:0]        w_res_hi;
    logic [31:0]        w_res_lo;

    assign w_is_mult  = (mdop == OP_MULT) || (mdop == OP_MULTU);
    assign w_is_md    = w_is_mult || (mdop == OP_DIV) || (mdop == OP_DIVU);
    assign w_is_valid = w_is_md || (mdop == OP_MTHI) || (mdop == OP_MTLO);

    // Only a real operation arriving while busy holds the pipeline.
    assign stall_req = start & r_busy & w_is_valid;

    // 64-bit signed operands keep 0x80000000 / -1 free of overflow.
    assign w_a_s    = {{32{A[31]}}, A};
    assign w_b_s    = {{32{B[31]}}, B};
    assign w_mul_s  = w_a_s * w_b_s;
    assign w_mul_u  = {32'd0, A} * {32'd0, B};
    assign w_div_q  = 32'(w_a_s / w_b_s);
    assign w_div_r  = 32'(w_a_s % w_b_s);
    assign w_divu_q = A / B;
    assign w_divu_r = A % B;

    // Divide by zero falls through to the current HI/LO so the write-back is a no-op.
    always_comb begin
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        case (mdop)
            OP_MULT: begin
                w_res_hi = w_mul_s[63:32];
                w_res_lo = w_mul_s[31:0];
            end
            OP_MULTU: begin
                w_res_hi = w_mul_u[63:32];
                w_res_lo = w_mul_u[31:0];
            end
            OP_DIV: begin
                if (B != 32'd0) begin
                    w_res_hi = w_div_r;
                    w_res_lo = w_div_q;
                end
            end
            OP_DIVU: begin
                if (B != 32'd0) begin
                    w_res_hi = w_divu_r;
                    w_res_lo = w_divu_q;
                end
            end
            default: begin
                w_res_hi = r_hi;
                w_res_lo = r_lo;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_temp_hi <= 32'd0;
            r_temp_lo <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && w_is_md) begin
                        r_temp_hi <= w_res_hi;
                        r_temp_lo <= w_res_lo;
                        r_cnt     <= w_is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        r_busy    <= 1'b1;
                        r_state   <= S_RUN;
                    end else if (start && (mdop == OP_MTHI)) begin
                        r_hi <= A;
                    end else if (start && (mdop == OP_MTLO)) begin
                        r_lo <= A;
                    end
                end
                S_RUN: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_hi    <= r_temp_hi;
                        r_lo    <= r_temp_lo;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed corner cases plus randomized operations
// checked against an arithmetic reference model of HI/LO and busy timing.
module tb_md_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  mdop;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall_req;

    int n_cmp;
    int n_err;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_unit #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mdop     (mdop),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo),
        .stall_req(stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: sign/magnitude division and wide products from the architectural rules.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] hi_i, input logic [31:0] lo_i,
                                  output logic [31:0] hi_o, output logic [31:0] lo_o);
        longint      ps;
        logic [63:0] pu;
        logic [31:0] ma, mb, q, r;
        hi_o = hi_i;
        lo_o = lo_i;
        case (op)
            3'd1: begin
                ps   = longint'($signed(a)) * longint'($signed(b));
                pu   = 64'(ps);
                hi_o = pu[63:32];
                lo_o = pu[31:0];
            end
            3'd2: begin
                pu   = 64'(a) * 64'(b);
                hi_o = pu[63:32];
                lo_o = pu[31:0];
            end
            3'd3: begin
                if (b != 32'd0) begin
                    ma = a[31] ? -a : a;
                    mb = b[31] ? -b : b;
                    q  = ma / mb;
                    r  = ma % mb;
                    if (a[31] != b[31]) q = -q;
                    if (a[31]) r = -r;
                    hi_o = r;
                    lo_o = q;
                end
            end
            3'd4: begin
                if (b != 32'd0) begin
                    hi_o = a % b;
                    lo_o = a / b;
                end
            end
            default: begin
                hi_o = hi_i;
                lo_o = lo_i;
            end
        endcase
    endfunction

    // Issue a multi-cycle op; optionally present another request in busy cycle ik.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int ik, input logic [2:0] iop, input logic [31:0] ia);
        logic [31:0] eh, el;
        int n;
        model(op, a, b, m_hi, m_lo, eh, el);
        n = (op <= 3'd2) ? MULT_N : DIV_N;
        start = 1'b1; mdop = op; A = a; B = b;
        #1;
        chk("accept_stall", 32'(stall_req), 32'd0);
        tick();
        start = 1'b0; mdop = 3'd0;
        for (int k = 1; k <= n; k++) begin
            chk("busy_run", 32'(busy), 32'd1);
            chk("hi_hold", hi, m_hi);
            chk("lo_hold", lo, m_lo);
            if (k == ik) begin
                start = 1'b1; mdop = iop; A = ia; B = $urandom;
                #1;
                chk("stall_busy", 32'(stall_req), (iop != 3'd0 && iop != 3'd7) ? 32'd1 : 32'd0);
            end
            tick();
            start = 1'b0; mdop = 3'd0;
        end
        m_hi = eh;
        m_lo = el;
        chk("busy_done", 32'(busy), 32'd0);
        chk("hi_result", hi, m_hi);
        chk("lo_result", lo, m_lo);
    endtask

    // Single-cycle request in IDLE: MTHI/MTLO or NONE/reserved.
    task automatic simple_op(input logic [2:0] op, input logic [31:0] a);
        start = 1'b1; mdop = op; A = a; B = $urandom;
        #1;
        chk("idle_stall", 32'(stall_req), 32'd0);
        tick();
        start = 1'b0; mdop = 3'd0;
        if (op == 3'd5) m_hi = a;
        if (op == 3'd6) m_lo = a;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_hi", hi, m_hi);
        chk("idle_lo", lo, m_lo);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] ra, rb;
        int sel;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1; start = 1'b1; mdop = 3'd5; A = 32'hCAFE_F00D; B = 32'd0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        reset = 1'b0; start = 1'b0; mdop = 3'd0;
        m_hi = 32'd0;
        m_lo = 32'd0;

        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 0, 3'd0, 32'd0);
        chk("mult_neg_hi", hi, 32'hFFFF_FFFF);
        chk("mult_neg_lo", lo, 32'hFFFF_FFFA);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 0, 3'd0, 32'd0);
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 0, 3'd0, 32'd0);
        chk("div_neg_lo", lo, 32'hFFFF_FFFD);
        chk("div_neg_hi", hi, 32'hFFFF_FFFF);
        simple_op(3'd5, 32'h11);
        simple_op(3'd6, 32'h22);
        run_op(3'd4, 32'd7, 32'd0, 0, 3'd0, 32'd0);
        chk("divz_hi", hi, 32'h11);
        chk("divz_lo", lo, 32'h22);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 3'd0, 32'd0);
        chk("div_ovf_lo", lo, 32'h8000_0000);
        chk("div_ovf_hi", hi, 32'd0);
        run_op(3'd1, 32'd1000, 32'hFFFF_FFF0, 2, 3'd5, 32'h1234);
        run_op(3'd3, 32'd77, 32'd5, 3, 3'd7, 32'h5555);
        run_op(3'd4, 32'd99, 32'd4, 4, 3'd0, 32'h6666);
        simple_op(3'd6, 32'hDEAD_BEEF);
        chk("mtlo_lo", lo, 32'hDEAD_BEEF);
        simple_op(3'd7, 32'h0BAD_0BAD);
        simple_op(3'd0, 32'h0BAD_0BAD);

        // Reset four edges into a divide aborts it.
        start = 1'b1; mdop = 3'd3; A = 32'd1000; B = 32'd7;
        tick();
        start = 1'b0; mdop = 3'd0;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("abort_busy_hold", 32'(busy), 32'd0);
            chk("abort_hi_hold", hi, 32'd0);
            chk("abort_lo_hold", lo, 32'd0);
        end

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: rb = 32'(rb[7:0]);
                default: ;
            endcase
            if (sel < 6) begin
                op = 3'($urandom_range(1, 4));
                run_op(op, ra, rb, $urandom_range(0, (op <= 3'd2) ? MULT_N : DIV_N),
                       3'($urandom_range(0, 7)), $urandom);
            end else if (sel < 9) begin
                simple_op(3'($urandom_range(5, 6)), ra);
            end else begin
                simple_op(($urandom_range(0, 1) == 0) ? 3'd0 : 3'd7, ra);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
